// File: rtl/fixed_pkg.sv
// Shared fixed-point types and constants for the sign-magnitude Q7.8 IIR datapath.
package fixed_pkg;

  localparam int WIDTH     = 16;
  localparam int FRAC_BITS = 8;

  localparam logic [WIDTH-2:0] MAG_MAX = '1;

  typedef struct packed {
    logic             sign;
    logic [WIDTH-2:0] mag;
  } sm_word_t;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_t;

  // Folds negative zero onto positive zero.
  function automatic sm_word_t normZero(input sm_word_t w);
    sm_word_t n;
    n.mag  = w.mag;
    n.sign = w.sign & (|w.mag);
    return n;
  endfunction

endpackage

// File: rtl/sm_addsub_core.sv
// Combinational magnitude add/sub with saturation and zero-sign normalisation.
module sm_addsub_core #(
  parameter int WIDTH = fixed_pkg::WIDTH
) (
  input  fixed_pkg::op_t   op,
  input  logic             sign,
  input  logic [WIDTH-2:0] magLarge,
  input  logic [WIDTH-2:0] magSmall,
  output logic [WIDTH-1:0] result,
  output logic             overflow
);
  import fixed_pkg::*;

  logic [WIDTH-1:0] magSum;
  logic [WIDTH-2:0] magOut;

  assign magSum = {1'b0, magLarge} + {1'b0, magSmall};

  always_comb begin
    magOut   = magLarge - magSmall;
    overflow = 1'b0;
    if (op == OP_ADD) begin
      magOut = magSum[WIDTH-2:0];
      if (magSum[WIDTH-1]) begin
        magOut   = '1;
        overflow = 1'b1;
      end
    end
  end

  // A zero magnitude always leaves as +0.
  assign result = {sign & (|magOut), magOut};

endmodule

// File: rtl/sm_subtractor_pipe.sv
// Two-stage sign-magnitude subtractor (A - B) with valid/ready on both sides and saturation.
module sm_subtractor_pipe #(
  parameter int WIDTH     = fixed_pkg::WIDTH,
  parameter int FRAC_BITS = fixed_pkg::FRAC_BITS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] inputA,
  input  logic [WIDTH-1:0] inputB,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] result,
  output logic             overflow,
  output logic             out_valid,
  input  logic             out_ready
);
  import fixed_pkg::*;

  localparam int MW = WIDTH - 1;

  logic [MW-1:0] magA, magB;
  logic          signA, signBEff;

  op_t           opNext;
  logic          signNext;
  logic [MW-1:0] largeNext, smallNext;

  logic          started;
  logic          s1Valid;
  op_t           s1Op;
  logic          s1Sign;
  logic [MW-1:0] s1Large, s1Small;

  logic          s2Move, s1Move, inXfer;
  logic [WIDTH-1:0] coreResult;
  logic             coreOverflow;

  assign magA     = inputA[MW-1:0];
  assign magB     = inputB[MW-1:0];
  assign signA    = inputA[WIDTH-1] & (|magA);
  assign signBEff = ~(inputB[WIDTH-1] & (|magB));

  always_comb begin
    opNext    = OP_ADD;
    signNext  = signA;
    largeNext = magA;
    smallNext = magB;
    if (signA != signBEff) begin
      opNext = OP_SUB;
      if (magA >= magB) begin
        signNext = (magA == magB) ? 1'b0 : signA;
      end else begin
        signNext  = signBEff;
        largeNext = magB;
        smallNext = magA;
      end
    end
  end

  // Ready path is combinational from out_ready; no skid buffer.
  assign s2Move   = !out_valid || out_ready;
  assign s1Move   = !s1Valid || s2Move;
  assign in_ready = started && s1Move;
  assign inXfer   = in_valid && in_ready;

  sm_addsub_core #(.WIDTH(WIDTH)) uCore (
    .op       (s1Op),
    .sign     (s1Sign),
    .magLarge (s1Large),
    .magSmall (s1Small),
    .result   (coreResult),
    .overflow (coreOverflow)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      started   <= 1'b0;
      s1Valid   <= 1'b0;
      s1Op      <= OP_ADD;
      s1Sign    <= 1'b0;
      s1Large   <= '0;
      s1Small   <= '0;
      out_valid <= 1'b0;
      result    <= '0;
      overflow  <= 1'b0;
    end else begin
      started <= 1'b1;
      if (s1Move) begin
        s1Valid <= inXfer;
        if (inXfer) begin
          s1Op    <= opNext;
          s1Sign  <= signNext;
          s1Large <= largeNext;
          s1Small <= smallNext;
        end
      end
      if (s2Move) begin
        out_valid <= s1Valid;
        if (s1Valid) begin
          result   <= coreResult;
          overflow <= coreOverflow;
        end
      end
    end
  end

endmodule
